// File: rtl/inv_mix_column.sv
// -----------------------------------------------------------------------------
// inv_mix_column
//
// Inverse Mix Column stage of the 16-bit nibble-oriented AES decryption round.
// The coefficient matrix [[K0,K1],[K1,K0]] over GF(2^4) is its own inverse, so
// the same coefficients undo the encryption-side transform. All eight nibble
// products share one bit-serial GF(2^4) multiplier. An IDLE/MUL FSM runs it for
// 8 products x 4 bits = 32 steps per word.
//
// Ports:
//   clk   in   1   clock, rising edge
//   rst   in   1   synchronous active-high reset
//   ld    in   1   start request, sampled only in IDLE (ignored while busy)
//   c     in  16   state word {s0,s1,s2,s3}, nibble s0 = c[15:12]
//   d     out 16   result word, held until the next completion or reset
//   dn    out  1   one-cycle done pulse, d valid when high
//   busy  out  1   high while the multiplier sequence runs
// -----------------------------------------------------------------------------
module inv_mix_column #(
    parameter logic [3:0] K0   = 4'd3,       // diagonal coefficient
    parameter logic [3:0] K1   = 4'd2,       // off-diagonal coefficient
    parameter logic [4:0] POLY = 5'b10011    // x^4 + x + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic [15:0] c,
    output logic [15:0] d,
    output logic        dn,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      opnd_q,  opnd_d;    // latched state word
    logic [3:0][3:0]  acc_q,   acc_d;     // acc[j] becomes result nibble j (j=0 -> d[15:12])
    logic [2:0]       prod_q,  prod_d;    // product index 0..7
    logic [1:0]       bit_q,   bit_d;     // step within product, 0 = coefficient MSB
    logic [3:0]       p_q,     p_d;       // partial product of the current multiply
    logic [15:0]      d_q,     d_d;
    logic             dn_q,    dn_d;

    // Multiplier operands for the current product.
    logic [3:0] coef;
    logic [3:0] nib;
    logic       coef_bit;
    logic [3:0] xt;
    logic [3:0] p_next;

    always_comb begin
        // Products 0,3,4,7 use K0 and 1,2,5,6 use K1; the nibble is
        // s{prod[2],prod[0]}, which walks s0,s1,s0,s1,s2,s3,s2,s3.
        coef = (prod_q[0] ^ prod_q[1]) ? K1 : K0;
        case ({prod_q[2], prod_q[0]})
            2'd0:    nib = opnd_q[15:12];
            2'd1:    nib = opnd_q[11:8];
            2'd2:    nib = opnd_q[7:4];
            default: nib = opnd_q[3:0];
        endcase
        // MSB-first scan of the coefficient.
        coef_bit = coef[2'd3 - bit_q];
        xt       = {p_q[2:0], 1'b0} ^ (p_q[3] ? POLY[3:0] : 4'h0);
        p_next   = xt ^ (coef_bit ? nib : 4'h0);
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement leaves one unassigned and infers a latch.
        state_d = state_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        bit_d   = bit_q;
        p_d     = p_q;
        d_d     = d_q;
        dn_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (ld) begin
                    opnd_d  = c;
                    acc_d   = '0;
                    prod_d  = 3'd0;
                    bit_d   = 2'd0;
                    p_d     = 4'h0;
                    state_d = MUL;
                end
            end
            MUL: begin
                p_d   = p_next;
                bit_d = bit_q + 2'd1;
                if (bit_q == 2'd3) begin
                    // Product complete: fold into accumulator prod>>1 and
                    // start the next product from zero.
                    acc_d[prod_q[2:1]] = acc_q[prod_q[2:1]] ^ p_next;
                    p_d    = 4'h0;
                    prod_d = prod_q + 3'd1;
                    if (prod_q == 3'd7) begin
                        d_d     = {acc_d[0], acc_d[1], acc_d[2], acc_d[3]};
                        dn_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the accumulators are ordinary flops, not a RAM, so they
            // are reset along with the rest of the state.
            state_q <= IDLE;
            opnd_q  <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            bit_q   <= '0;
            p_q     <= '0;
            d_q     <= '0;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            bit_q   <= bit_d;
            p_q     <= p_d;
            d_q     <= d_d;
            dn_q    <= dn_d;
        end
    end

    assign d    = d_q;
    assign dn   = dn_q;
    assign busy = (state_q == MUL);

endmodule

// File: tb/tb_inv_mix_column.sv
// -----------------------------------------------------------------------------
// tb_inv_mix_column
//
// Self-checking bench for inv_mix_column. Expected words come from a plain
// GF(2^4) matrix-multiply model (shift-and-add, LSB first). Inputs are driven
// and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_inv_mix_column;

    logic        clk;
    logic        rst;
    logic        ld;
    logic [15:0] c;
    logic [15:0] d;
    logic        dn;
    logic        busy;

    int checks;
    int errors;
    logic [15:0] last_d;   // value d must hold between completions

    inv_mix_column dut (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .c    (c),
        .d    (d),
        .dn   (dn),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] x;
        r = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ x;
            x = x[3] ? ((x << 1) ^ 4'h3) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [15:0] model(input logic [15:0] w);
        logic [3:0] s [4];
        logic [3:0] m [2][2];
        logic [3:0] r [4];
        for (int i = 0; i < 4; i++) s[i] = w[15 - 4*i -: 4];
        m[0][0] = 4'd3; m[0][1] = 4'd2;
        m[1][0] = 4'd2; m[1][1] = 4'd3;
        for (int col = 0; col < 2; col++)
            for (int row = 0; row < 2; row++)
                r[2*col + row] = gmul(m[row][0], s[2*col]) ^ gmul(m[row][1], s[2*col + 1]);
        return {r[0], r[1], r[2], r[3]};
    endfunction

    // ------------------------------------------------------------- helpers
    task automatic start_op(input logic [15:0] cval);
        @(negedge clk);
        ld = 1'b1;
        c  = cval;
    endtask

    // Watches one operation whose ld was driven on the previous falling edge.
    // Falling edge k follows rising edge E0+k-1, so dn is due at k = 33.
    // inj_at > 0 re-asserts ld with inj_c while busy; chain = 1 asserts ld
    // with chain_c in the dn cycle and returns so the next watch follows on.
    task automatic watch(input string name, input logic [15:0] exp,
                         input int inj_at, input logic [15:0] inj_c,
                         input bit chain, input logic [15:0] chain_c);
        int   dn_cnt;
        int   dn_at;
        logic [15:0] d_at_dn;
        bit   busy_ok;
        bit   hold_ok;
        dn_cnt  = 0;
        dn_at   = -1;
        d_at_dn = 16'hxxxx;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (dn === 1'b1) begin
                dn_cnt++;
                if (dn_at < 0) begin
                    dn_at   = k;
                    d_at_dn = d;
                end
            end
            if (k <= 32 && busy !== 1'b1) busy_ok = 1'b0;
            if (k >= 33 && busy !== 1'b0) busy_ok = 1'b0;
            if (k <= 32 && d !== last_d)  hold_ok = 1'b0;
            if (chain && k == 33) begin
                ld = 1'b1;
                c  = chain_c;
                break;
            end
            ld = (k == inj_at);
            if (k == inj_at) c = inj_c;
        end
        checks++;
        if (dn_cnt !== 1) begin
            errors++;
            $display("FAIL %s dn_count: got %0d expected 1", name, dn_cnt);
        end
        checks++;
        if (dn_at !== 33) begin
            errors++;
            $display("FAIL %s dn_latency: got %0d expected 32", name, dn_at - 1);
        end
        checks++;
        if (d_at_dn !== exp) begin
            errors++;
            $display("FAIL %s d: got %h expected %h", name, d_at_dn, exp);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s busy_window: got wrong busy level, expected high for 32 cycles", name);
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL %s d_hold: got change before dn, expected %h held", name, last_d);
        end
        if (dn_at == 33) last_d = exp;
        else last_d = d;
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        bit stable;
        rst = 1'b1;
        ld  = 1'b0;
        c   = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL reset_d: got %h expected 0000", d);
        end
        checks++;
        if (dn !== 1'b0) begin
            errors++;
            $display("FAIL reset_dn: got %b expected 0", dn);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        stable = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (d !== 16'h0000 || dn !== 1'b0 || busy !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL idle_stable: got activity with ld=0, expected none");
        end
        last_d = 16'h0000;
    endtask

    task automatic test_vectors();
        logic [15:0] vin [8];
        logic [15:0] vout[8];
        vin[0] = 16'h1000; vout[0] = 16'h3200;
        vin[1] = 16'h0100; vout[1] = 16'h2300;
        vin[2] = 16'h0010; vout[2] = 16'h0032;
        vin[3] = 16'h0000; vout[3] = 16'h0000;
        vin[4] = 16'h9A00; vout[4] = 16'hFC00;
        vin[5] = 16'hFC00; vout[5] = 16'h9A00;
        vin[6] = 16'hFFFF; vout[6] = 16'hFFFF;
        vin[7] = 16'h3200; vout[7] = 16'h1000;
        for (int i = 0; i < 8; i++) begin
            start_op(vin[i]);
            watch($sformatf("vec_%h", vin[i]), vout[i], 0, 16'h0, 1'b0, 16'h0);
        end
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int i = 0; i < 12; i++) begin
            w = 16'($urandom);
            start_op(w);
            watch($sformatf("rand_%h", w), model(w), 0, 16'h0, 1'b0, 16'h0);
        end
    endtask

    task automatic test_ld_while_busy();
        logic [15:0] w;
        logic [15:0] junk;
        int at;
        start_op(16'h1000);
        watch("ld_busy_fixed", 16'h3200, 11, 16'hFFFF, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            w    = 16'($urandom);
            junk = 16'($urandom);
            at   = $urandom_range(1, 32);
            start_op(w);
            watch($sformatf("ld_busy_%h_at%0d", w, at), model(w), at, junk, 1'b0, 16'h0);
        end
    endtask

    task automatic test_back_to_back();
        start_op(16'h0100);
        watch("b2b_first", 16'h2300, 0, 16'h0, 1'b1, 16'h9A00);
        watch("b2b_second", 16'hFC00, 0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic test_reset_mid_op();
        bit no_dn;
        start_op(16'h9A00);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            ld = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_busy: got %b expected 0", busy);
        end
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_d: got %h expected 0000", d);
        end
        no_dn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dn !== 1'b0 || busy !== 1'b0) no_dn = 1'b0;
        end
        checks++;
        if (!no_dn) begin
            errors++;
            $display("FAIL midrst_no_dn: got dn or busy after abort, expected none");
        end
        last_d = 16'h0000;
        start_op(16'h9A00);
        watch("midrst_restart", 16'hFC00, 0, 16'h0, 1'b0, 16'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_d = 16'h0000;
        test_reset();
        test_vectors();
        test_random();
        test_ld_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_mix_column.md
# inv_mix_column

Inverse Mix Column stage for the decryption datapath of the 16-bit nibble-oriented AES design. It undoes the encryption-side Mix Column transform. The default coefficient matrix [[3,2],[2,3]] over GF(2^4) mod x^4+x+1 is involutory, so inversion uses the same coefficients. It uses one shared bit-serial GF(2^4) multiplier sequenced by an FSM, not eight parallel multipliers. The block sits between inverse Add Round Key and inverse Shift Row in each decryption round and uses the same ld/dn handshake as the other round stages.

## Interface
- K0, 4'd3, diagonal coefficient
- K1, 4'd2, off-diagonal coefficient
- POLY, 5'b10011, GF(2^4) reduction polynomial (x^4+x+1)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; one clock, reset is synchronous and active-high
- ld  input  1  start request, sampled in IDLE only
- c  input  16  state word; nibbles s0=c[15:12], s1=c[11:8], s2=c[7:4], s3=c[3:0]
- d  output  16  result word, held until the next completion
- dn  output  1  one-cycle done pulse; d valid when high
- busy  output  1  high while computing

## Operation
- Result nibbles (· = GF(2^4) multiply mod POLY, ^ = XOR):
  - d[15:12] = K0·s0 ^ K1·s1
  - d[11:8] = K1·s0 ^ K0·s1
  - d[7:4] = K0·s2 ^ K1·s3
  - d[3:0] = K1·s2 ^ K0·s3
- FSM states: IDLE, MUL.
  - IDLE + ld=1: latch c into operand registers, clear the four 4-bit accumulators, clear the product index (3b) and bit index (2b), go to MUL.
  - IDLE + ld=0: stay.
  - MUL: one multiplier step per cycle.
  - MUL, last bit of product 7: go to IDLE.
- Product order, index 0..7:
  - 0: K0·s0, 1: K1·s1, 2: K1·s0, 3: K0·s1, 4: K0·s2, 5: K1·s3, 6: K1·s2, 7: K0·s3.
  - Product k XORs into accumulator k>>1.
- Serial multiply a·b, MSB-first over b[3:0]:
  - Per step: p = xtime(p) ^ (b[i] ? a : 0).
  - xtime(p) = {p[2:0],1'b0} ^ (p[3] ? POLY[3:0] : 0).
  - p clears at the start of each product. After 4 steps p is XORed into its accumulator.
- On the final step, d <= all four accumulators (including the last product) and dn <= 1.
- ld while busy=1 is ignored; the operand registers do not change.
- d is not cleared in IDLE. It changes only at completion or reset.
- All arithmetic is 4-bit. There is no carry or overflow; reduction keeps every intermediate 4 bits wide.

## Timing
- Reset (rst=1 at a rising edge): state=IDLE, d=16'h0000, dn=0, busy=0, counters=0, accumulators=0.
- Reset mid-operation aborts the computation. No dn is produced, and d reads 0.
- Let E0 be the edge where ld=1 is sampled in IDLE.
  - busy is high from E0 to E0+32.
  - The 32 multiplier steps occur at edges E0+1..E0+32.
  - d updates and dn rises at E0+32. dn falls at E0+33.
  - Latency is 32 cycles from ld sample to dn.
- While dn=1 the state is IDLE, so ld=1 in the dn cycle is accepted. The next result arrives 32 cycles later, giving back-to-back throughput of one result per 33 cycles.
- c need only be stable at E0.

## Test plan
- Reset: rst=1 for 2 cycles, then 0 -> d=16'h0000, dn=0, busy=0. With ld=0, no state change for 50 cycles.
- Basis vectors:
  - c=16'h1000 -> d=16'h3200
  - c=16'h0100 -> d=16'h2300
  - c=16'h0010 -> d=16'h0032
  - c=16'h0000 -> d=16'h0000
  - Each: dn exactly one cycle, exactly 32 cycles after ld.
- Reduction and involution:
  - c=16'h9A00 -> d=16'hFC00
  - c=16'hFC00 -> d=16'h9A00
  - c=16'hFFFF -> d=16'hFFFF
  - c=16'h3200 -> d=16'h1000
- ld while busy: ld=1 with c=16'h1000. At cycle +10, ld=1 with c=16'hFFFF -> single dn at +32, d=16'h3200, no second dn.
- Back-to-back: ld=1 with c=16'h0100, then ld=1 again during the dn cycle with c=16'h9A00 -> d=16'h2300 at +32, then d=16'hFC00 at +65. d holds 16'h2300 in between.
- Reset mid-op: ld=1 with c=16'h9A00, rst=1 at cycle +15 -> busy=0, d=0, no dn. After a fresh ld with c=16'h9A00, d=16'hFC00.
